mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-requester arbiter and sequencer for the single shared data-memory bus. The pipeline's MEM-stage port (MemRead/MemWrite/MemAddr/WriteData/ReadData) is one requester; a DMA/peripheral master is the other. The block serialises their accesses, inserts a configurable number of memory wait states, and drives a combinational stall back to the pipeline until the CPU access completes.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `WAIT_STATES`, default 1: extra memory cycles per access; range 0–15.

- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `cpu_req`  input  1  CPU access request (MemRead | MemWrite); level, held until ack.
- `cpu_we`  input  1  1 = write, 0 = read.
- `cpu_addr`  input  AW  byte address (ALUResult_MEM).
- `cpu_wdata`  input  DW  store data.
- `cpu_rdata`  output  DW  load data.
- `cpu_ack`  output  1  one-cycle completion pulse.
- `cpu_stall`  output  1  `cpu_req & ~cpu_ack`, combinational; freezes PC and all pipeline registers.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`  input  1/1/AW/DW  DMA request; same semantics as the CPU port.
- `dma_rdata`  output  DW  DMA load data.
- `dma_ack`  output  1  DMA completion pulse.
- `mem_en`, `mem_we`  output  1/1  memory strobe and write enable.
- `mem_addr`, `mem_wdata`  output  AW/DW  memory address and store data.
- `mem_rdata`  input  DW  combinational read data; valid in the final access cycle.

## Operation
- FSM states:
  - IDLE.
  - BUSY: carries a 1-bit `owner` and a 4-bit `cnt`.
- IDLE:
  - If any request is present, arbitrate, then latch `owner`, `we`, `addr` and `wdata` into internal registers.
  - Set `cnt = WAIT_STATES` and move to BUSY.
  - No request: stay in IDLE; `mem_en = 0`.
- BUSY:
  - `mem_en = 1`; `mem_we`, `mem_addr` and `mem_wdata` come from the latched registers and are stable for the whole access.
  - `cnt != 0`: decrement `cnt`.
  - `cnt == 0`: assert the owner's ack for this cycle only, then return to IDLE.
- Read data:
  - During the ack cycle of a read, the owner's `rdata` = `mem_rdata` (pass-through).
  - On that edge the value is captured into the owner's hold register.
  - Outside the ack cycle, `rdata` = hold register.
  - Write acks do not update the hold register.
- Arbitration: default fixed priority, CPU wins over DMA.
- Withdrawal: dropping a request while it is in BUSY does not abort the access. The access completes and ack still pulses (no torn writes).
- Requests arriving during BUSY wait; for the CPU, `cpu_stall` stays high until its own ack.
- One idle turnaround cycle between accesses: back-to-back requests are granted on the cycle after an ack.

## Timing
- Request first sampled in IDLE at cycle N: BUSY during N+1 … N+1+WAIT_STATES; ack at cycle N+1+WAIT_STATES.
- CPU latency with the bus free: WAIT_STATES+2 cycles from `cpu_req` rising to `cpu_stall` falling (stall high in cycles N … N+WAIT_STATES, low in the ack cycle).
- Reset values, applied asynchronously on `reset = 0`:
  - State IDLE, `cnt = 0`, `owner = CPU`, last-owner = DMA.
  - Hold registers 0; `mem_en`, `mem_we`, both acks 0.
  - `mem_addr`, `mem_wdata`, `cpu_rdata`, `dma_rdata` all 0.
- Reset mid-BUSY: the access is abandoned, `mem_en` drops immediately (asynchronously) and no ack is issued.
- `cpu_stall` reflects `cpu_req` combinationally, so it is high in the same cycle a load/store enters MEM, with no one-cycle hole.
- `WAIT_STATES = 0`: every access occupies exactly one BUSY cycle.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - When both requests are present in IDLE, grant goes to the requester that was not granted last; the last-owner register updates on every grant.
  - A single requester is always granted immediately.
- Not defined:
  - Fixed priority, CPU first.
  - The last-owner register is not implemented.
  - DMA can starve under continuous CPU traffic.

## Test plan
- CPU read alone, WAIT_STATES=1, addr 0x10, `mem_rdata` 0xDEADBEEF:
  - `cpu_stall` high for 2 cycles; `cpu_ack` in the 3rd cycle with `cpu_rdata` = 0xDEADBEEF.
  - `cpu_rdata` still 0xDEADBEEF afterwards.
- CPU write 0x12345678 to 0x20 during a pending DMA write 0xAAAA0000 to 0x30, both raised in the same cycle, fixed priority:
  - CPU is granted first, then one IDLE cycle, then DMA.
  - `mem_addr` sequence: 0x20, then 0x30.
- Same simultaneous requests with `ARB_ROUND_ROBIN_EN` and last owner = CPU: DMA is granted first; a repeated simultaneous pair is then granted to the CPU.
- DMA read in BUSY, `dma_req` dropped after 1 cycle: the access still completes, `dma_ack` pulses once, `dma_rdata` is updated.
- `reset` asserted in the middle of a WAIT_STATES=3 CPU write: `mem_en` goes to 0 in the same cycle; after release the FSM is in IDLE, no ack has pulsed, and the re-held `cpu_req` is re-granted.
- WAIT_STATES=0 with back-to-back CPU loads:
  - Each load shows 1 stall cycle and an ack on the 2nd cycle.
  - `mem_en` is low for exactly one cycle between the two accesses.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-requester (CPU/DMA) arbiter and wait-state sequencer for the shared data-memory bus.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on contention instead of CPU-first.
module mem_bus_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] hold_cpu_q, hold_dma_q;
  logic          gnt_dma;
  logic          grant;
  logic          done;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q;

  // last_q = 1 means DMA held the bus last, so CPU wins the next tie
  assign gnt_dma = dma_req & (~cpu_req | ~last_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= 1'b1;
    end else if (grant) begin
      last_q <= gnt_dma;
    end
  end
`else
  assign gnt_dma = dma_req & ~cpu_req;
`endif

  assign grant = (state_q == IDLE) & (cpu_req | dma_req);
  assign done  = (state_q == BUSY) & (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          owner_d = gnt_dma;
          we_d    = gnt_dma ? dma_we    : cpu_we;
          addr_d  = gnt_dma ? dma_addr  : cpu_addr;
          wdata_d = gnt_dma ? dma_wdata : cpu_wdata;
          cnt_d   = WS;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Read data is captured only on read acks; write acks leave the hold intact
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cpu_q <= '0;
      hold_dma_q <= '0;
    end else begin
      if (cpu_ack && !we_q) hold_cpu_q <= mem_rdata;
      if (dma_ack && !we_q) hold_dma_q <= mem_rdata;
    end
  end

  assign cpu_ack   = done & ~owner_q;
  assign dma_ack   = done & owner_q;
  assign cpu_stall = cpu_req & ~cpu_ack;

  assign mem_en    = (state_q == BUSY);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign cpu_rdata = (cpu_ack && !we_q) ? mem_rdata : hold_cpu_q;
  assign dma_rdata = (dma_ack && !we_q) ? mem_rdata : hold_dma_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: three instances (WAIT_STATES 1, 3, 0)
// share all inputs; each scenario resets them all and checks one instance.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;

  logic [31:0] cpu_rdata [3];
  logic [31:0] dma_rdata [3];
  logic [31:0] mem_addr  [3];
  logic [31:0] mem_wdata [3];
  logic        cpu_ack   [3];
  logic        cpu_stall [3];
  logic        dma_ack   [3];
  logic        mem_en    [3];
  logic        mem_we    [3];

  int n_tests = 0;
  int n_fail  = 0;
  int ack1_cnt = 0;
  int dack0_cnt = 0;
  int ord [3];
  int n_ord;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_bus_arbiter #(
      .AW(32),
      .DW(32),
      .WAIT_STATES(g == 0 ? 1 : (g == 1 ? 3 : 0))
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .cpu_req  (cpu_req),
      .cpu_we   (cpu_we),
      .cpu_addr (cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata[g]),
      .cpu_ack  (cpu_ack[g]),
      .cpu_stall(cpu_stall[g]),
      .dma_req  (dma_req),
      .dma_we   (dma_we),
      .dma_addr (dma_addr),
      .dma_wdata(dma_wdata),
      .dma_rdata(dma_rdata[g]),
      .dma_ack  (dma_ack[g]),
      .mem_en   (mem_en[g]),
      .mem_we   (mem_we[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cpu_ack[1]) ack1_cnt++;
    if (dma_ack[0]) dack0_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset     = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    dma_req   = 1'b0;
    dma_we    = 1'b0;
    dma_addr  = '0;
    dma_wdata = '0;
    mem_rdata = '0;
    step;
    step;
    reset = 1'b1;
  endtask

  // Runs instance 0 until both requests are served; DMA re-requests
  // right after each of its first dma_rep acks. Records ack order.
  task automatic serve(input int dma_rep);
    logic ca, da;
    int   rep;
    rep   = dma_rep;
    n_ord = 0;
    for (int c = 0; c < 40 && (cpu_req || dma_req); c++) begin
      @(negedge clk);
      ca = cpu_ack[0];
      da = dma_ack[0];
      if (ca && n_ord < 3) begin ord[n_ord] = 0; n_ord++; end
      if (da && n_ord < 3) begin ord[n_ord] = 1; n_ord++; end
      step;
      if (ca) cpu_req = 1'b0;
      if (da) begin
        if (rep > 0) rep--;
        else dma_req = 1'b0;
      end
    end
    chk("serve_timeout", {30'd0, cpu_req, dma_req}, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    do_reset;

    // reset state
    @(negedge clk);
    chk("rst_en", mem_en[0], 0);
    chk("rst_we", mem_we[0], 0);
    chk("rst_addr", mem_addr[0], 0);
    chk("rst_rdata", cpu_rdata[0], 0);
    chk("rst_ack", cpu_ack[0], 0);
    step;

    // CPU read alone, WAIT_STATES=1
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("rd_c0_stall", cpu_stall[0], 1);
    chk("rd_c0_en", mem_en[0], 0);
    step;
    @(negedge clk);
    chk("rd_c1_stall", cpu_stall[0], 1);
    chk("rd_c1_en", mem_en[0], 1);
    chk("rd_c1_addr", mem_addr[0], 32'h10);
    chk("rd_c1_ack", cpu_ack[0], 0);
    step;
    @(negedge clk);
    chk("rd_c2_ack", cpu_ack[0], 1);
    chk("rd_c2_stall", cpu_stall[0], 0);
    chk("rd_c2_rdata", cpu_rdata[0], 32'hDEADBEEF);
    step;
    cpu_req = 0; mem_rdata = 32'h0;
    @(negedge clk);
    chk("rd_c3_hold", cpu_rdata[0], 32'hDEADBEEF);
    chk("rd_c3_ack", cpu_ack[0], 0);
    chk("rd_c3_en", mem_en[0], 0);
    step;

    // simultaneous writes from reset: CPU first in both arbitration modes
    do_reset;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'h12345678;
    dma_req = 1; dma_we = 1; dma_addr = 32'h30; dma_wdata = 32'hAAAA0000;
    @(negedge clk);
    chk("wr_c0_en", mem_en[0], 0);
    step;
    @(negedge clk);
    chk("wr_c1_en", mem_en[0], 1);
    chk("wr_c1_we", mem_we[0], 1);
    chk("wr_c1_addr", mem_addr[0], 32'h20);
    chk("wr_c1_wdata", mem_wdata[0], 32'h12345678);
    step;
    @(negedge clk);
    chk("wr_c2_cack", cpu_ack[0], 1);
    chk("wr_c2_dack", dma_ack[0], 0);
    step;
    cpu_req = 0;
    @(negedge clk);
    chk("wr_c3_turn", mem_en[0], 0);
    step;
    @(negedge clk);
    chk("wr_c4_en", mem_en[0], 1);
    chk("wr_c4_addr", mem_addr[0], 32'h30);
    chk("wr_c4_wdata", mem_wdata[0], 32'hAAAA0000);
    step;
    @(negedge clk);
    chk("wr_c5_dack", dma_ack[0], 1);
    chk("wr_c5_cpu_rd", cpu_rdata[0], 0);
    step;
    dma_req = 0;
    @(negedge clk);
    chk("wr_c6_en", mem_en[0], 0);
    step;

    // arbitration order after a CPU-only access (last owner = CPU)
    do_reset;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h70;
    serve(0);
    chk("arb_warm", ord[0], 0);
    cpu_req = 1; dma_req = 1; dma_we = 1; dma_addr = 32'h74;
    serve(1);
    chk("arb_n", n_ord, 3);
`ifdef ARB_ROUND_ROBIN_EN
    chk("arb_0", ord[0], 1);
    chk("arb_1", ord[1], 0);
    chk("arb_2", ord[2], 1);
`else
    chk("arb_0", ord[0], 0);
    chk("arb_1", ord[1], 1);
    chk("arb_2", ord[2], 1);
`endif

    // DMA read withdrawn after one cycle still completes
    do_reset;
    dma_req = 1; dma_we = 0; dma_addr = 32'h40;
    @(negedge clk);
    dack0_cnt = 0;
    step;
    dma_req = 0;
    @(negedge clk);
    chk("wd_c1_en", mem_en[0], 1);
    chk("wd_c1_addr", mem_addr[0], 32'h40);
    step;
    mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("wd_c2_ack", dma_ack[0], 1);
    chk("wd_c2_rdata", dma_rdata[0], 32'hCAFEF00D);
    step;
    mem_rdata = 32'h0;
    @(negedge clk);
    chk("wd_c3_hold", dma_rdata[0], 32'hCAFEF00D);
    chk("wd_c3_en", mem_en[0], 0);
    step;
    step;
    chk("wd_pulses", dack0_cnt, 1);

    // reset in the middle of a WAIT_STATES=3 CPU write
    do_reset;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h50; cpu_wdata = 32'h55;
    @(negedge clk);
    ack1_cnt = 0;
    chk("rm_c0_en", mem_en[1], 0);
    step;
    @(negedge clk);
    chk("rm_c1_en", mem_en[1], 1);
    step;
    @(negedge clk);
    chk("rm_c2_en", mem_en[1], 1);
    reset = 0;
    #1;
    chk("rm_async_en", mem_en[1], 0);
    chk("rm_async_ack", cpu_ack[1], 0);
    step;
    reset = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rm_re_c%0d_ack", k), cpu_ack[1], 0);
      step;
    end
    chk("rm_no_ack", ack1_cnt, 0);
    @(negedge clk);
    chk("rm_re_ack", cpu_ack[1], 1);
    chk("rm_re_addr", mem_addr[1], 32'h50);
    step;
    cpu_req = 0;

    // WAIT_STATES=0 back-to-back CPU loads
    do_reset;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h60; mem_rdata = 32'h11111111;
    @(negedge clk);
    chk("z_c0_stall", cpu_stall[2], 1);
    chk("z_c0_en", mem_en[2], 0);
    step;
    @(negedge clk);
    chk("z_c1_ack", cpu_ack[2], 1);
    chk("z_c1_stall", cpu_stall[2], 0);
    chk("z_c1_rdata", cpu_rdata[2], 32'h11111111);
    step;
    cpu_addr = 32'h64; mem_rdata = 32'h22222222;
    @(negedge clk);
    chk("z_c2_en", mem_en[2], 0);
    chk("z_c2_stall", cpu_stall[2], 1);
    chk("z_c2_rdata", cpu_rdata[2], 32'h11111111);
    step;
    @(negedge clk);
    chk("z_c3_en", mem_en[2], 1);
    chk("z_c3_addr", mem_addr[2], 32'h64);
    chk("z_c3_ack", cpu_ack[2], 1);
    chk("z_c3_rdata", cpu_rdata[2], 32'h22222222);
    step;
    cpu_req = 0;
    @(negedge clk);
    chk("z_c4_en", mem_en[2], 0);
    chk("z_c4_hold", cpu_rdata[2], 32'h22222222);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
